// File: rtl/system_onchip_mem_arbiter_pkg.sv
// Shared types and constants for the on-chip memory arbiter.
// Holds the FSM state enum, default widths and the index-width helper.
package system_mem_arb_pkg;

    localparam int DEF_N_REQ  = 10;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;
    localparam int BE_W       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } arb_state_e;

    // Bits needed to index n requesters; never less than 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/system_onchip_mem_arbiter_if.sv
// Requester-side and RAM-side bus bundle for the memory arbiter.
// slave: the arbiter's view. master: the requesters/RAM environment view.
interface system_onchip_mem_arbiter_if
    import system_mem_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [N_REQ-1:0]        req_read;
    logic [N_REQ-1:0]        req_write;
    logic [N_REQ*ADDR_W-1:0] req_address;
    logic [N_REQ*DATA_W-1:0] req_writedata;
    logic [N_REQ*BE_W-1:0]   req_byteenable;
    logic [N_REQ-1:0]        req_lock;
    logic [N_REQ-1:0]        req_waitrequest;
    logic [N_REQ-1:0]        req_readdatavalid;
    logic [DATA_W-1:0]       req_readdata;

    logic [ADDR_W-1:0]       mem_address;
    logic [DATA_W-1:0]       mem_writedata;
    logic [BE_W-1:0]         mem_byteenable;
    logic                    mem_chipselect;
    logic                    mem_write;
    logic                    mem_clken;
    logic [DATA_W-1:0]       mem_readdata;

    modport slave (
        input  req_read, req_write, req_address, req_writedata, req_byteenable, req_lock,
        output req_waitrequest, req_readdatavalid, req_readdata,
        output mem_address, mem_writedata, mem_byteenable, mem_chipselect, mem_write, mem_clken,
        input  mem_readdata
    );

    modport master (
        output req_read, req_write, req_address, req_writedata, req_byteenable, req_lock,
        input  req_waitrequest, req_readdatavalid, req_readdata,
        input  mem_address, mem_writedata, mem_byteenable, mem_chipselect, mem_write, mem_clken,
        output mem_readdata
    );

endinterface

// File: rtl/system_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping at N_REQ. Returns one-hot grant and its index.
module system_rr_picker
    import system_mem_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] sel;
    logic             found;

    // Walk the requesters starting at ptr, take the first one asking.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        sel   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N_REQ))
                cand = cand - (IDX_W+1)'(N_REQ);
            sel = cand[IDX_W-1:0];
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                idx        = sel;
            end
        end
    end

endmodule

// File: rtl/system_onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among N_REQ requesters.
// IDLE picks a winner, ACCESS drives the RAM for one cycle, RDATA returns
// read data one cycle later. Optional grant locking: SYSTEM_MEM_ARB_LOCK_EN.
module system_onchip_mem_arbiter
    import system_mem_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                          clk,
    input  logic                          reset,
    system_onchip_mem_arbiter_if.slave    bus
);

    localparam int IDX_W = clog2(N_REQ);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [N_REQ-1:0] grant_oh_q, grant_oh_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [N_REQ-1:0] req_any;
    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             sel_read, sel_write, sel_active;
    logic [IDX_W-1:0] ptr_after;

    logic [ADDR_W-1:0] addr_arr [N_REQ];
    logic [DATA_W-1:0] wdata_arr [N_REQ];
    logic [BE_W-1:0]   be_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign addr_arr[i]  = bus.req_address[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = bus.req_writedata[i*DATA_W +: DATA_W];
        assign be_arr[i]    = bus.req_byteenable[i*BE_W +: BE_W];
    end

    assign req_any    = bus.req_read | bus.req_write;
    assign sel_read   = bus.req_read[grant_idx_q];
    assign sel_write  = bus.req_write[grant_idx_q];
    assign sel_active = sel_read | sel_write;
    assign ptr_after  = (grant_idx_q == IDX_W'(N_REQ-1)) ? '0 : grant_idx_q + 1'b1;

    system_rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
        .req   (req_any),
        .ptr   (rr_ptr_q),
        .grant (pick_oh),
        .idx   (pick_idx)
    );

`ifndef SYSTEM_MEM_ARB_LOCK_EN
    // Lock requests have no effect in this build.
    logic unused_lock;
    assign unused_lock = ^bus.req_lock;
`endif

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            grant_oh_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            grant_oh_q  <= grant_oh_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Next-state: arbitrate in IDLE, leave ACCESS after one cycle.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        grant_oh_d  = grant_oh_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (|req_any) begin
                    grant_idx_d = pick_idx;
                    grant_oh_d  = pick_oh;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                // Write wins over read, so only a pure read needs RDATA.
                state_d  = (sel_active && !sel_write) ? RDATA : IDLE;
                rr_ptr_d = ptr_after;
`ifdef SYSTEM_MEM_ARB_LOCK_EN
                // Park the pointer on a locking owner so it wins next time.
                if (bus.req_lock[grant_idx_q])
                    rr_ptr_d = grant_idx_q;
`endif
            end
            RDATA:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs; forced idle while reset is high so nothing leaks out.
    always_comb begin
        bus.req_waitrequest   = '1;
        bus.req_readdatavalid = '0;
        bus.req_readdata      = '0;
        bus.mem_address       = '0;
        bus.mem_writedata     = '0;
        bus.mem_byteenable    = '0;
        bus.mem_chipselect    = 1'b0;
        bus.mem_write         = 1'b0;
        bus.mem_clken         = 1'b1;
        if (!reset) begin
            case (state_q)
                ACCESS: begin
                    if (sel_active) begin
                        bus.mem_chipselect  = 1'b1;
                        bus.mem_write       = sel_write;
                        bus.mem_address     = addr_arr[grant_idx_q];
                        bus.mem_writedata   = wdata_arr[grant_idx_q];
                        bus.mem_byteenable  = be_arr[grant_idx_q];
                        bus.req_waitrequest = ~grant_oh_q;
                    end
                end
                RDATA: begin
                    bus.req_readdatavalid = grant_oh_q;
                    bus.req_readdata      = bus.mem_readdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_system_onchip_mem_arbiter.sv
// Scoreboard bench for system_onchip_mem_arbiter: expected grants and read
// data are queued at stimulus time and popped as the DUT accepts/returns.
module tb_system_onchip_mem_arbiter;

    localparam int N = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    system_onchip_mem_arbiter_if #(.N_REQ(N), .ADDR_W(16), .DATA_W(32)) bus ();

    system_onchip_mem_arbiter #(.N_REQ(N), .ADDR_W(16), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM model: registered read, byte-enabled write.
    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (bus.mem_chipselect && bus.mem_clken) begin
            if (bus.mem_write)
                for (int b = 0; b < 4; b++)
                    if (bus.mem_byteenable[b])
                        ram[bus.mem_address[7:0]][b*8 +: 8] <= bus.mem_writedata[b*8 +: 8];
            bus.mem_readdata <= ram[bus.mem_address[7:0]];
        end
    end

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        lock;
        logic        lat;
    } op_t;

    typedef struct {
        int          id;
        logic [31:0] data;
    } rd_t;

    op_t ops [N][8];
    int  n_ops [N];
    int  head [N];
    int  iss [N];
    logic [N-1:0] rd_lat = '0;
    int  exp_gnt [$];
    rd_t exp_rd [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic load(input int i);
        op_t op;
        if (head[i] < n_ops[i]) begin
            op = ops[i][head[i]];
            bus.req_write[i] = op.wr;
            bus.req_read[i]  = !op.wr;
            bus.req_address[i*16 +: 16]   = op.addr;
            bus.req_writedata[i*32 +: 32] = op.data;
            bus.req_byteenable[i*4 +: 4]  = op.be;
            bus.req_lock[i] = op.lock;
            iss[i] = cyc;
        end else begin
            bus.req_write[i] = 1'b0;
            bus.req_read[i]  = 1'b0;
            bus.req_lock[i]  = 1'b0;
        end
    endtask

    task automatic add_op(input int i, input logic wr, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          input logic lk, input logic lat);
        ops[i][n_ops[i]] = '{wr: wr, addr: a, data: d, be: be, lock: lk, lat: lat};
        n_ops[i]++;
    endtask

    task automatic clear_ops();
        for (int i = 0; i < N; i++) begin
            n_ops[i] = 0;
            head[i]  = 0;
        end
    endtask

    task automatic kick();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) load(i);
    endtask

    task automatic wait_done(input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge clk); #2;
            done = (exp_gnt.size() == 0) && (exp_rd.size() == 0);
            for (int i = 0; i < N; i++)
                if (head[i] < n_ops[i]) done = 1'b0;
        end
        chk("timeout", {63'd0, done}, 64'd1);
        repeat (2) @(posedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    // Monitor: score accepts and read strobes, then advance requester ops.
    initial begin
        logic [N-1:0] acc;
        op_t op;
        forever begin
            @(negedge clk);
            acc = '0;
            for (int i = 0; i < N; i++) begin
                if (!bus.req_waitrequest[i]) begin
                    acc[i] = 1'b1;
                    if (exp_gnt.size() == 0) chk("grant_unexp", 64'(i), 64'd99);
                    else                     chk("grant", 64'(i), 64'(exp_gnt.pop_front()));
                    if (head[i] < n_ops[i]) begin
                        op = ops[i][head[i]];
                        chk("mem_cs", {63'd0, bus.mem_chipselect}, 64'd1);
                        chk("mem_clken", {63'd0, bus.mem_clken}, 64'd1);
                        chk("mem_we", {63'd0, bus.mem_write}, {63'd0, op.wr});
                        chk("mem_addr", {48'd0, bus.mem_address}, {48'd0, op.addr});
                        if (op.wr) begin
                            chk("mem_wdata", {32'd0, bus.mem_writedata}, {32'd0, op.data});
                            chk("mem_be", {60'd0, bus.mem_byteenable}, {60'd0, op.be});
                        end
                        if (op.lat) begin
                            chk("acc_lat", 64'(cyc - iss[i]), 64'd1);
                            if (!op.wr) rd_lat[i] = 1'b1;
                        end
                    end else begin
                        chk("acc_no_op", 64'(head[i]), 64'(n_ops[i]));
                    end
                end
                if (bus.req_readdatavalid[i]) begin
                    if (exp_rd.size() == 0) begin
                        chk("rdv_unexp", 64'(i), 64'd99);
                    end else begin
                        rd_t e;
                        e = exp_rd.pop_front();
                        chk("rd_id", 64'(i), 64'(e.id));
                        chk("rd_data", {32'd0, bus.req_readdata}, {32'd0, e.data});
                    end
                    if (rd_lat[i]) begin
                        chk("rd_lat", 64'(cyc - iss[i]), 64'd2);
                        rd_lat[i] = 1'b0;
                    end
                end
            end
            @(posedge clk); #1;
            for (int i = 0; i < N; i++)
                if (acc[i]) begin
                    head[i]++;
                    load(i);
                end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_read = '0;
        bus.req_write = '0;
        bus.req_address = '0;
        bus.req_writedata = '0;
        bus.req_byteenable = '0;
        bus.req_lock = '0;
        clear_ops();

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wait", 64'(bus.req_waitrequest), 64'h3FF);
        chk("rst_rdv", 64'(bus.req_readdatavalid), 64'd0);
        chk("rst_cs", {63'd0, bus.mem_chipselect}, 64'd0);
        chk("rst_we", {63'd0, bus.mem_write}, 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_wait", 64'(bus.req_waitrequest), 64'h3FF);
        chk("post_rst_cs", {63'd0, bus.mem_chipselect}, 64'd0);

        // Single write, then read-back, with latency checks.
        clear_ops();
        add_op(3, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1);
        exp_gnt.push_back(3);
        kick();
        wait_done(20);

        clear_ops();
        add_op(3, 1'b0, 16'h0010, 32'h0, 4'hF, 1'b0, 1'b1);
        exp_gnt.push_back(3);
        exp_rd.push_back('{id: 3, data: 32'hDEADBEEF});
        kick();
        wait_done(20);

        // All requesters read continuously from reset: 0..9 twice.
        pulse_reset();
        clear_ops();
        for (int i = 0; i < N; i++) begin
            add_op(i, 1'b0, 16'h0010, 32'h0, 4'hF, 1'b0, 1'b0);
            add_op(i, 1'b0, 16'h0010, 32'h0, 4'hF, 1'b0, 1'b0);
        end
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) begin
                exp_gnt.push_back(i);
                exp_rd.push_back('{id: i, data: 32'hDEADBEEF});
            end
        kick();
        wait_done(200);

        // Partial byte-enable write merges into existing word.
        clear_ops();
        add_op(2, 1'b1, 16'h0020, 32'hAAAAAAAA, 4'hF, 1'b0, 1'b0);
        add_op(2, 1'b1, 16'h0020, 32'h11223344, 4'h3, 1'b0, 1'b0);
        add_op(2, 1'b0, 16'h0020, 32'h0, 4'hF, 1'b0, 1'b0);
        repeat (3) exp_gnt.push_back(2);
        exp_rd.push_back('{id: 2, data: 32'hAAAA3344});
        kick();
        wait_done(40);

        // Lock: requester 5 holds the grant for its three writes.
        clear_ops();
        for (int k = 0; k < 3; k++)
            add_op(5, 1'b1, 16'h0030 + 16'(k), 32'h5000 + 32'(k), 4'hF, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++)
            add_op(6, 1'b1, 16'h0040 + 16'(k), 32'h6000 + 32'(k), 4'hF, 1'b0, 1'b0);
`ifdef SYSTEM_MEM_ARB_LOCK_EN
        exp_gnt.push_back(5); exp_gnt.push_back(5); exp_gnt.push_back(5);
        exp_gnt.push_back(6); exp_gnt.push_back(6);
`else
        exp_gnt.push_back(5); exp_gnt.push_back(6); exp_gnt.push_back(5);
        exp_gnt.push_back(6); exp_gnt.push_back(5);
`endif
        kick();
        wait_done(60);

        // Reset during RDATA aborts the read strobe.
        clear_ops();
        add_op(4, 1'b0, 16'h0010, 32'h0, 4'hF, 1'b0, 1'b0);
        exp_gnt.push_back(4);
        kick();
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(posedge clk); #2;
                seen = (head[4] == 1);
            end
            chk("rdata_reach", {63'd0, seen}, 64'd1);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rdata_rdv", 64'(bus.req_readdatavalid), 64'd0);
        chk("rst_rdata_wait", 64'(bus.req_waitrequest), 64'h3FF);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("after_rst_wait", 64'(bus.req_waitrequest), 64'h3FF);
        chk("after_rst_rdv", 64'(bus.req_readdatavalid), 64'd0);
        chk("after_rst_cs", {63'd0, bus.mem_chipselect}, 64'd0);
        repeat (3) @(posedge clk);

        // Granted requester drops its request in ACCESS: no access, pointer advances.
        clear_ops();
        @(posedge clk); #1;
        bus.req_address[7*16 +: 16] = 16'h0010;
        bus.req_read[7] = 1'b1;
        @(posedge clk); #1;
        bus.req_read[7] = 1'b0;
        @(negedge clk);
        chk("drop_cs", {63'd0, bus.mem_chipselect}, 64'd0);
        chk("drop_wait", 64'(bus.req_waitrequest), 64'h3FF);
        @(posedge clk); #1;
        clear_ops();
        add_op(7, 1'b1, 16'h0050, 32'h77777777, 4'hF, 1'b0, 1'b0);
        add_op(9, 1'b1, 16'h0051, 32'h99999999, 4'hF, 1'b0, 1'b0);
        exp_gnt.push_back(9);
        exp_gnt.push_back(7);
        kick();
        wait_done(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/system_onchip_mem_arbiter.md
SYSTEM_ONCHIP_MEM_ARBITER -- requirements
Module: system_onchip_mem_arbiter

Interface
REQ-001 Parameters SHALL be:
- N_REQ, 10, number of requesters (SHA cores), 2..16
- ADDR_W, 16, word address width
- DATA_W, 32, data width
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  sole clock
- reset  in  1  synchronous active-high reset
- req_read  in  N_REQ  per-requester read request
- req_write  in  N_REQ  per-requester write request
- req_address  in  N_REQ*ADDR_W  packed word addresses, requester i at slice i
- req_writedata  in  N_REQ*DATA_W  packed write data
- req_byteenable  in  N_REQ*4  packed byte enables
- req_lock  in  N_REQ  keep grant for next access
- req_waitrequest  out  N_REQ  1 = request not yet accepted
- req_readdatavalid  out  N_REQ  1-cycle read-data strobe
- req_readdata  out  DATA_W  read data shared by all requesters; valid only with its strobe
- mem_address  out  ADDR_W  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_byteenable  out  4  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_clken  out  1  to RAM
- mem_readdata  in  DATA_W  from RAM; valid 1 cycle after the address is presented

Function
REQ-004 States SHALL be IDLE, ACCESS and RDATA.
REQ-005 IDLE: if any req_read|req_write is set, the winner SHALL be the first set bit searching upward from rr_ptr with wrap; the grant index is registered and the state moves to ACCESS; otherwise the block stays in IDLE.
REQ-006 ACCESS:
- mem_chipselect=1; mem_address, mem_writedata and mem_byteenable are driven from the granted slice.
- mem_write equals req_write of the granted requester.
- req_waitrequest[g]=0 for exactly this cycle.
REQ-007 ACCESS exit: a write SHALL return to IDLE; a read SHALL go to RDATA.
REQ-008 RDATA: req_readdatavalid[g]=1 and req_readdata=mem_readdata; the state returns to IDLE.
REQ-009 Latency from request to acceptance with no contention SHALL be 1 cycle; read data arrives 2 cycles after the request.
REQ-010 Outside their accept and strobe cycles, req_waitrequest SHALL be 1 and req_readdatavalid SHALL be 0.
REQ-011 rr_ptr SHALL be set to (g+1) mod N_REQ when the state leaves ACCESS.
REQ-012 If req_read and req_write are both set for one requester, the write SHALL take priority.
REQ-013 If the granted requester deasserts its request in ACCESS:
- no memory access: mem_chipselect=0;
- waitrequest stays 1;
- the state returns to IDLE; rr_ptr still advances.
REQ-014 mem_clken SHALL be held at 1.
REQ-015 Fairness: each continuously-requesting requester SHALL be served within N_REQ accesses.

Reset
REQ-016 On reset the block SHALL enter IDLE with rr_ptr=0 and the grant index at 0.
REQ-017 During and after reset the outputs SHALL be:
- req_waitrequest all 1s;
- req_readdatavalid 0;
- mem_chipselect=0 and mem_write=0.
REQ-018 Reset asserted mid-transaction SHALL abort it: no readdatavalid is issued, and any write not yet clocked in ACCESS is not performed.

Configuration
REQ-019 Macro SYSTEM_MEM_ARB_LOCK_EN, when defined: if req_lock[g]=1 in ACCESS, rr_ptr SHALL stay at g, and g wins the next IDLE arbitration if it is requesting.
REQ-020 Macro undefined: req_lock SHALL be ignored, and rr_ptr always advances per REQ-011.

Structure
REQ-021 Package system_mem_arb_pkg SHALL hold:
- the state enum;
- default width constants;
- the index-width function clog2(N_REQ).
REQ-022 Sub-module system_rr_picker SHALL be a combinational round-robin picker (request vector + pointer -> one-hot grant + index), instantiated once.

Verification
REQ-023 Single write: req_write[3]=1, address 0x0010, data 0xDEADBEEF, byteenable 0xF -> waitrequest[3]=0 in cycle 2 and a RAM write with those values.
REQ-024 Read-back of that write: req_read[3]=1, address 0x0010 -> readdatavalid[3]=1 with readdata 0xDEADBEEF, 2 cycles after the request.
REQ-025 All 10 requesters read continuously from reset -> grant order 0,1,…,9,0; no requester starved.
REQ-026 Byteenable 0x3 write of 0x11223344 over 0xAAAAAAAA -> read returns 0xAAAA3344.
REQ-027 With SYSTEM_MEM_ARB_LOCK_EN, requester 5 locks for 3 writes while 6 requests -> 5,5,5 then 6; without the macro -> 5,6,5,6.
REQ-028 Reset asserted in RDATA -> no readdatavalid, and all waitrequest=1 on the next edge.
